// File: rtl/term_writer.sv
// Character terminal writer: turns a CPU character stream into display-memory writes.
// Define TERM_SCROLL_EN to scroll the screen up at the bottom row instead of wrapping to row 0.
//
// state     | meaning
// IDLE      | waiting for a character, char_ready high
// WRITE     | one cycle after a transfer; carries the cell write, if there is one
// SCROLL_RD | read strobe on a source cell one row below its destination
// SCROLL_WR | write of the returned data one row up
// CLEAR     | one BLANK write per cycle from ptr up to end_addr
module term_writer #(
    parameter int         COLS  = 40,
    parameter int         ROWS  = 30,
    parameter logic [7:0] BLANK = 8'h20
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [7:0]  char_in,
    input  logic        char_valid,
    output logic        char_ready,
    output logic [11:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [7:0]  mem_rdata,
    output logic [5:0]  cursor_col,
    output logic [4:0]  cursor_row,
    output logic        busy
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] WRITE     = 3'd1;
    localparam logic [2:0] SCROLL_RD = 3'd2;
    localparam logic [2:0] SCROLL_WR = 3'd3;
    localparam logic [2:0] CLEAR     = 3'd4;

`ifdef TERM_SCROLL_EN
    localparam logic SCROLL_EN = 1'b1;
`else
    localparam logic SCROLL_EN = 1'b0;
`endif

    localparam logic [5:0]  COL_MAX       = 6'(COLS - 1);
    localparam logic [4:0]  ROW_MAX       = 5'(ROWS - 1);
    localparam logic [11:0] COLS_A        = 12'(COLS);
    localparam logic [11:0] LAST_ADDR     = 12'(COLS * ROWS - 1);
    localparam logic [11:0] LAST_ROW_BASE = 12'((ROWS - 1) * COLS);

    logic [2:0]  state;
    logic [11:0] ptr;
    logic [11:0] end_addr;
    logic        wrap_pend;
    logic        armed;
    logic        re_q;
    logic [7:0]  wdata_q;
    logic [4:0]  adv_row;
    logic        adv_wrap;

    function automatic logic [11:0] cell_addr(input logic [4:0] r, input logic [5:0] c);
        return 12'(int'(r) * COLS + int'(c));
    endfunction

    // Line advance; at the bottom row the actual move is finished after the WRITE cycle
    always_comb begin
        adv_wrap = (cursor_row == ROW_MAX);
        adv_row  = cursor_row + 5'd1;
        if (adv_wrap) begin
            adv_row = SCROLL_EN ? ROW_MAX : 5'd0;
        end
    end

    assign char_ready = armed && (state == IDLE);
    assign busy       = (state != IDLE);
    assign mem_re     = re_q & SCROLL_EN;
    // Scroll data passes straight from the read port, valid in the SCROLL_WR cycle
    assign mem_wdata  = (state == SCROLL_WR) ? mem_rdata : wdata_q;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state      <= IDLE;
            ptr        <= '0;
            end_addr   <= '0;
            wrap_pend  <= 1'b0;
            armed      <= 1'b0;
            re_q       <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            wdata_q    <= '0;
            cursor_col <= '0;
            cursor_row <= '0;
        end else begin
            armed <= 1'b1;
            case (state)
                IDLE: begin
                    if (char_valid && char_ready) begin
                        state     <= WRITE;
                        wrap_pend <= 1'b0;
                        if (char_in >= 8'h20) begin
                            mem_we   <= 1'b1;
                            mem_addr <= cell_addr(cursor_row, cursor_col);
                            wdata_q  <= char_in;
                            if (cursor_col == COL_MAX) begin
                                cursor_col <= '0;
                                cursor_row <= adv_row;
                                wrap_pend  <= adv_wrap;
                            end else begin
                                cursor_col <= cursor_col + 6'd1;
                            end
                        end else begin
                            case (char_in)
                                8'h0A: begin
                                    cursor_col <= '0;
                                    cursor_row <= adv_row;
                                    wrap_pend  <= adv_wrap;
                                end
                                8'h0D: cursor_col <= '0;
                                8'h08: begin
                                    if (cursor_col != 6'd0) begin
                                        cursor_col <= cursor_col - 6'd1;
                                        mem_we     <= 1'b1;
                                        mem_addr   <= cell_addr(cursor_row, cursor_col - 6'd1);
                                        wdata_q    <= BLANK;
                                    end
                                end
                                8'h0C: begin
                                    state      <= CLEAR;
                                    cursor_col <= '0;
                                    cursor_row <= '0;
                                    ptr        <= '0;
                                    end_addr   <= LAST_ADDR;
                                    mem_we     <= 1'b1;
                                    mem_addr   <= '0;
                                    wdata_q    <= BLANK;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                WRITE: begin
                    mem_we <= 1'b0;
                    if (!wrap_pend) begin
                        state <= IDLE;
                    end else if (SCROLL_EN) begin
                        state    <= SCROLL_RD;
                        ptr      <= COLS_A;
                        re_q     <= 1'b1;
                        mem_addr <= COLS_A;
                    end else begin
                        state    <= CLEAR;
                        ptr      <= '0;
                        end_addr <= COLS_A - 12'd1;
                        mem_we   <= 1'b1;
                        mem_addr <= '0;
                        wdata_q  <= BLANK;
                    end
                end
                SCROLL_RD: begin
                    state    <= SCROLL_WR;
                    re_q     <= 1'b0;
                    mem_we   <= 1'b1;
                    mem_addr <= ptr - COLS_A;
                end
                SCROLL_WR: begin
                    if (ptr == LAST_ADDR) begin
                        state    <= CLEAR;
                        ptr      <= LAST_ROW_BASE;
                        end_addr <= LAST_ADDR;
                        mem_addr <= LAST_ROW_BASE;
                        wdata_q  <= BLANK;
                    end else begin
                        state    <= SCROLL_RD;
                        mem_we   <= 1'b0;
                        re_q     <= 1'b1;
                        ptr      <= ptr + 12'd1;
                        mem_addr <= ptr + 12'd1;
                    end
                end
                CLEAR: begin
                    if (ptr == end_addr) begin
                        state  <= IDLE;
                        mem_we <= 1'b0;
                    end else begin
                        ptr      <= ptr + 12'd1;
                        mem_addr <= ptr + 12'd1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    mem_we <= 1'b0;
                    re_q   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_term_writer.sv
// Bench for term_writer: a behavioural display memory plus a cursor/write model feeding
// an expected-write queue that is compared against the writes seen on the memory port.
module tb_term_writer;

    localparam int         COLS  = 40;
    localparam int         ROWS  = 30;
    localparam logic [7:0] BLANK = 8'h20;
    localparam int         LIMIT = 5000;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic [7:0]  char_in = 8'h00;
    logic        char_valid = 1'b0;
    logic        char_ready;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [7:0]  mem_rdata = 8'h00;
    logic [5:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic        busy;

    int total = 0;
    int bad   = 0;

    logic [7:0]  mem [0:4095];
    logic        fill_req = 1'b0;
    logic [19:0] exp_q[$];
    logic [19:0] obs_q[$];
    int both_cnt = 0;
    int idle_we_cnt = 0;
    int re_cnt = 0;
    int ec = 0;
    int er = 0;

    term_writer #(.COLS(COLS), .ROWS(ROWS), .BLANK(BLANK)) dut (
        .clk(clk), .clr(clr), .char_in(char_in), .char_valid(char_valid),
        .char_ready(char_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata),
        .cursor_col(cursor_col), .cursor_row(cursor_row), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (fill_req) begin
            for (int a = 0; a < 4096; a++) mem[a] <= 8'(a * 13 + 5);
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    always @(negedge clk) begin
        if (mem_we) obs_q.push_back({mem_addr, mem_wdata});
        if (mem_we && mem_re) both_cnt++;
        if (mem_we && !busy) idle_we_cnt++;
        if (mem_re) re_cnt++;
    end

    task automatic advance();
        if (er < ROWS - 1) begin
            er++;
        end else begin
`ifdef TERM_SCROLL_EN
            for (int a = COLS; a < COLS * ROWS; a++) exp_q.push_back({12'(a - COLS), mem[a]});
            for (int a = (ROWS - 1) * COLS; a < COLS * ROWS; a++) exp_q.push_back({12'(a), BLANK});
`else
            er = 0;
            for (int a = 0; a < COLS; a++) exp_q.push_back({12'(a), BLANK});
`endif
        end
    endtask

    task automatic model(input logic [7:0] c);
        if (c >= 8'h20) begin
            exp_q.push_back({12'(er * COLS + ec), c});
            if (ec == COLS - 1) begin
                ec = 0;
                advance();
            end else begin
                ec++;
            end
        end else if (c == 8'h0A) begin
            ec = 0;
            advance();
        end else if (c == 8'h0D) begin
            ec = 0;
        end else if (c == 8'h08) begin
            if (ec > 0) begin
                ec--;
                exp_q.push_back({12'(er * COLS + ec), BLANK});
            end
        end else if (c == 8'h0C) begin
            for (int a = 0; a < COLS * ROWS; a++) exp_q.push_back({12'(a), BLANK});
            ec = 0;
            er = 0;
        end
    endtask

    task automatic send(input logic [7:0] c);
        int n;
        @(negedge clk);
        n = 0;
        while (!char_ready && n < LIMIT) begin @(negedge clk); n++; end
        model(c);
        char_in = c;
        char_valid = 1'b1;
        @(posedge clk); #1;
        char_valid = 1'b0;
        char_in = 8'h00;
        @(negedge clk);
        while (!char_ready && n < LIMIT) begin @(negedge clk); n++; end
        if (n >= LIMIT) begin
            total++; bad++;
            $display("FAIL send_timeout code=%h busy=%b required idle", c, busy);
        end
    endtask

    task automatic test_reset();
        #12;
        total++;
        if ({char_ready, busy, mem_we, mem_re} !== 4'b0000) begin
            bad++; $display("FAIL reset_strobes got=%b required=0000", {char_ready, busy, mem_we, mem_re});
        end
        total++;
        if ({mem_addr, mem_wdata, cursor_col, cursor_row} !== 31'd0) begin
            bad++; $display("FAIL reset_values got addr=%h wdata=%h col=%0d row=%0d required all 0",
                            mem_addr, mem_wdata, cursor_col, cursor_row);
        end
        @(negedge clk); #1;
        clr = 1'b1;
        total++;
        if (char_ready !== 1'b0) begin bad++; $display("FAIL ready_before_edge got=%b required=0", char_ready); end
        @(posedge clk); #1;
        total++;
        if (char_ready !== 1'b1) begin bad++; $display("FAIL ready_after_edge got=%b required=1", char_ready); end
    endtask

    task automatic test_first_char();
        @(negedge clk);
        model(8'h41);
        char_in = 8'h41;
        char_valid = 1'b1;
        @(posedge clk); #1;
        char_valid = 1'b0;
        char_in = 8'h00;
        @(negedge clk);
        total++;
        if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 12'd0, 8'h41}) begin
            bad++; $display("FAIL first_write got we=%b addr=%0d data=%h required we=1 addr=0 data=41",
                            mem_we, mem_addr, mem_wdata);
        end
        @(negedge clk);
        total++;
        if (mem_we !== 1'b0) begin bad++; $display("FAIL first_we_pulse got=%b required=0", mem_we); end
        total++;
        if (cursor_col !== 6'd1 || cursor_row !== 5'd0) begin
            bad++; $display("FAIL first_cursor got=(%0d,%0d) required=(1,0)", cursor_col, cursor_row);
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_form_feed();
        int cnt;
        logic [19:0] e, o;
        @(negedge clk);
        model(8'h0C);
        char_in = 8'h0C;
        char_valid = 1'b1;
        @(posedge clk); #1;
        char_valid = 1'b0;
        cnt = 0;
        @(negedge clk);
        while (busy && cnt < LIMIT) begin cnt++; @(negedge clk); end
        total++;
        if (cnt != COLS * ROWS) begin bad++; $display("FAIL ff_busy_cycles got=%0d required=%0d", cnt, COLS * ROWS); end
        total++;
        if (idle_we_cnt != 0) begin bad++; $display("FAIL ff_we_not_busy got=%0d required=0", idle_we_cnt); end
        total++;
        if (cursor_col !== 6'd0 || cursor_row !== 5'd0) begin
            bad++; $display("FAIL ff_cursor got=(%0d,%0d) required=(0,0)", cursor_col, cursor_row);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 20'hxxxxx;
            total++;
            if (o !== e) begin
                bad++; $display("FAIL ff_write got=%h/%h required=%h/%h", o[19:8], o[7:0], e[19:8], e[7:0]);
            end
        end
        total++;
        if (obs_q.size() != 0) begin bad++; $display("FAIL ff_extra got=%0d required=0", obs_q.size()); end
        obs_q.delete();
    endtask

    task automatic test_line_wrap();
        logic [19:0] e, o;
        send(8'h0A);
        send(8'h0A);
        for (int i = 0; i < COLS - 1; i++) send(8'h78);
        total++;
        if (cursor_col !== 6'd39 || cursor_row !== 5'd2) begin
            bad++; $display("FAIL wrap_pre_cursor got=(%0d,%0d) required=(39,2)", cursor_col, cursor_row);
        end
        send(8'h42);
        total++;
        if (obs_q.size() == 0 || obs_q[obs_q.size() - 1] !== {12'd119, 8'h42}) begin
            bad++; $display("FAIL wrap_write got entries=%0d required last=119/42", obs_q.size());
        end
        total++;
        if (cursor_col !== 6'd0 || cursor_row !== 5'd3) begin
            bad++; $display("FAIL wrap_cursor got=(%0d,%0d) required=(0,3)", cursor_col, cursor_row);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 20'hxxxxx;
            total++;
            if (o !== e) begin
                bad++; $display("FAIL wrap_stream got=%h/%h required=%h/%h", o[19:8], o[7:0], e[19:8], e[7:0]);
            end
        end
        total++;
        if (obs_q.size() != 0) begin bad++; $display("FAIL wrap_extra got=%0d required=0", obs_q.size()); end
        obs_q.delete();
    endtask

    task automatic test_backspace();
        logic [19:0] e, o;
        int n;
        send(8'h0A);
        for (int i = 0; i < 5; i++) send(8'h79);
        send(8'h08);
        total++;
        if (obs_q.size() == 0 || obs_q[obs_q.size() - 1] !== {12'd164, BLANK}) begin
            bad++; $display("FAIL bs_write got entries=%0d required last=164/20", obs_q.size());
        end
        total++;
        if (cursor_col !== 6'd4 || cursor_row !== 5'd4) begin
            bad++; $display("FAIL bs_cursor got=(%0d,%0d) required=(4,4)", cursor_col, cursor_row);
        end
        n = obs_q.size();
        send(8'h0D);
        send(8'h08);
        send(8'h01);
        total++;
        if (obs_q.size() != n) begin bad++; $display("FAIL bs_col0_write got=%0d new writes required=0", obs_q.size() - n); end
        total++;
        if (cursor_col !== 6'd0 || cursor_row !== 5'd4) begin
            bad++; $display("FAIL bs_col0_cursor got=(%0d,%0d) required=(0,4)", cursor_col, cursor_row);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 20'hxxxxx;
            total++;
            if (o !== e) begin
                bad++; $display("FAIL bs_stream got=%h/%h required=%h/%h", o[19:8], o[7:0], e[19:8], e[7:0]);
            end
        end
        total++;
        if (obs_q.size() != 0) begin bad++; $display("FAIL bs_extra got=%0d required=0", obs_q.size()); end
        obs_q.delete();
    endtask

    task automatic test_scroll();
        logic [19:0] e, o;
        @(negedge clk);
        fill_req = 1'b1;
        @(negedge clk);
        fill_req = 1'b0;
        while (er < ROWS - 1) send(8'h0A);
        exp_q.delete();
        obs_q.delete();
        both_cnt = 0;
        send(8'h0A);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 20'hxxxxx;
            total++;
            if (o !== e) begin
                bad++; $display("FAIL scroll_stream got=%h/%h required=%h/%h", o[19:8], o[7:0], e[19:8], e[7:0]);
            end
        end
        total++;
        if (obs_q.size() != 0) begin bad++; $display("FAIL scroll_extra got=%0d required=0", obs_q.size()); end
        obs_q.delete();
        total++;
        if (both_cnt != 0) begin bad++; $display("FAIL we_re_overlap got=%0d required=0", both_cnt); end
`ifdef TERM_SCROLL_EN
        total++;
        if (mem[0] !== 8'(40 * 13 + 5)) begin bad++; $display("FAIL scroll_addr0 got=%h required=%h", mem[0], 8'(40 * 13 + 5)); end
        total++;
        if (mem[1159] !== 8'(1199 * 13 + 5)) begin bad++; $display("FAIL scroll_addr1159 got=%h required=%h", mem[1159], 8'(1199 * 13 + 5)); end
        for (int a = 1160; a < 1200; a++) begin
            total++;
            if (mem[a] !== BLANK) begin bad++; $display("FAIL scroll_last_row addr=%0d got=%h required=%h", a, mem[a], BLANK); end
        end
        total++;
        if (cursor_col !== 6'd0 || cursor_row !== 5'd29) begin
            bad++; $display("FAIL scroll_cursor got=(%0d,%0d) required=(0,29)", cursor_col, cursor_row);
        end
`else
        for (int a = 0; a < COLS; a++) begin
            total++;
            if (mem[a] !== BLANK) begin bad++; $display("FAIL wrap_row0 addr=%0d got=%h required=%h", a, mem[a], BLANK); end
        end
        total++;
        if (mem[40] !== 8'(40 * 13 + 5)) begin bad++; $display("FAIL wrap_row1_kept got=%h required=%h", mem[40], 8'(40 * 13 + 5)); end
        total++;
        if (re_cnt != 0) begin bad++; $display("FAIL wrap_mem_re got=%0d required=0", re_cnt); end
        total++;
        if (cursor_col !== 6'd0 || cursor_row !== 5'd0) begin
            bad++; $display("FAIL wrap_bottom_cursor got=(%0d,%0d) required=(0,0)", cursor_col, cursor_row);
        end
`endif
    endtask

    task automatic test_reset_mid_scroll();
        while (er < ROWS - 1) send(8'h0A);
        @(negedge clk);
        model(8'h0A);
        char_in = 8'h0A;
        char_valid = 1'b1;
        @(posedge clk); #1;
        char_valid = 1'b0;
        char_in = 8'h00;
        repeat (15) @(posedge clk);
        #3;
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy got=%b required=1", busy); end
        clr = 1'b0;
        #1;
        total++;
        if ({char_ready, busy, mem_we, mem_re} !== 4'b0000) begin
            bad++; $display("FAIL mid_reset_strobes got=%b required=0000", {char_ready, busy, mem_we, mem_re});
        end
        total++;
        if ({mem_addr, mem_wdata, cursor_col, cursor_row} !== 31'd0) begin
            bad++; $display("FAIL mid_reset_values got addr=%h wdata=%h col=%0d row=%0d required all 0",
                            mem_addr, mem_wdata, cursor_col, cursor_row);
        end
        ec = 0;
        er = 0;
        exp_q.delete();
        @(negedge clk);
        clr = 1'b1;
        #1;
        total++;
        if (char_ready !== 1'b0) begin bad++; $display("FAIL mid_ready_before_edge got=%b required=0", char_ready); end
        @(posedge clk); #1;
        total++;
        if (char_ready !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL mid_ready_after_edge got ready=%b busy=%b required ready=1 busy=0", char_ready, busy);
        end
        obs_q.delete();
    endtask

    initial begin
        test_reset();
        test_first_char();
        test_form_feed();
        test_line_wrap();
        test_backspace();
        test_scroll();
        test_reset_mid_scroll();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
